// File: rtl/seg_scan6_if.sv
// Display-side bundle between the clock datapath and the 6-digit scanner.
// SEG_SCAN6_BLINK_EN adds the per-pair blink request.
interface seg_scan6_if;
  logic       en;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
`ifdef SEG_SCAN6_BLINK_EN
  logic [2:0] blink;
`endif
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

`ifdef SEG_SCAN6_BLINK_EN
  modport master (output en, hour, minute, second, blink,
                  input  an, seg, dp, frame_start);
  modport slave  (input  en, hour, minute, second, blink,
                  output an, seg, dp, frame_start);
`else
  modport master (output en, hour, minute, second,
                  input  an, seg, dp, frame_start);
  modport slave  (input  en, hour, minute, second,
                  output an, seg, dp, frame_start);
`endif
endinterface

// File: rtl/seg_scan6.sv
// 6-digit multiplexed 7-segment scanner with per-frame time snapshot.
// Optional per-pair blinking under SEG_SCAN6_BLINK_EN.
module seg_scan6 #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
`ifdef SEG_SCAN6_BLINK_EN
  , parameter int BLINK_LOG2 = 24
`endif
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  seg_scan6_if.slave   disp_if
);
  localparam int DW = $clog2(SCAN_DIV);

  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [4:0]    sh_hour_q, sh_hour_d;
  logic [5:0]    sh_min_q, sh_min_d;
  logic [5:0]    sh_sec_q, sh_sec_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;
  logic          tick;
  logic [3:0]    sec_t, sec_o, min_t, min_o, hr_t, hr_o;
  logic [3:0]    dval;
  logic          dash;

  function automatic logic [6:0] bcd7(input logic [3:0] d);
    case (d)
      4'd0: bcd7 = 7'b1000000;
      4'd1: bcd7 = 7'b1111001;
      4'd2: bcd7 = 7'b0100100;
      4'd3: bcd7 = 7'b0110000;
      4'd4: bcd7 = 7'b0011001;
      4'd5: bcd7 = 7'b0010010;
      4'd6: bcd7 = 7'b0000010;
      4'd7: bcd7 = 7'b1111000;
      4'd8: bcd7 = 7'b0000000;
      4'd9: bcd7 = 7'b0010000;
      default: bcd7 = 7'b1111111;
    endcase
  endfunction

`ifdef SEG_SCAN6_BLINK_EN
  logic [BLINK_LOG2-1:0] blink_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) blink_cnt_q <= '0;
    else         blink_cnt_q <= blink_cnt_q + 1'b1;
`endif

  assign tick = (div_cnt_q == DW'(SCAN_DIV - 1));

  // Prescaler, digit index and snapshot
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    dig_d     = dig_q;
    sh_hour_d = sh_hour_q;
    sh_min_d  = sh_min_q;
    sh_sec_d  = sh_sec_q;
    fs_d      = 1'b0;
    if (tick) begin
      dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
      if (dig_q == 3'd5) begin
        sh_hour_d = disp_if.hour;
        sh_min_d  = disp_if.minute;
        sh_sec_d  = disp_if.second;
        fs_d      = 1'b1;
      end
    end
  end

  // Binary-to-BCD split of the shadowed time
  always_comb begin
    sec_t = 4'(sh_sec_q / 6'd10);
    sec_o = 4'(sh_sec_q % 6'd10);
    min_t = 4'(sh_min_q / 6'd10);
    min_o = 4'(sh_min_q % 6'd10);
    hr_t  = 4'(sh_hour_q / 5'd10);
    hr_o  = 4'(sh_hour_q % 5'd10);
  end

  always_comb begin
    dval = 4'd0;
    dash = 1'b0;
    case (dig_q)
      3'd0: begin dval = sec_o; dash = (sh_sec_q  >= 6'd60); end
      3'd1: begin dval = sec_t; dash = (sh_sec_q  >= 6'd60); end
      3'd2: begin dval = min_o; dash = (sh_min_q  >= 6'd60); end
      3'd3: begin dval = min_t; dash = (sh_min_q  >= 6'd60); end
      3'd4: begin dval = hr_o;  dash = (sh_hour_q >= 5'd24); end
      3'd5: begin dval = hr_t;  dash = (sh_hour_q >= 5'd24); end
      default: begin dval = 4'd0; dash = 1'b0; end
    endcase
  end

  // Registered display drive; seg/dp keep the digit through the blank window
  always_comb begin
    seg_d = dash ? SEG_DASH : bcd7(dval);
    dp_d  = !((dig_q == 3'd2) || (dig_q == 3'd4));
    if (!disp_if.en || (div_cnt_q < DW'(BLANK_CYCLES)))
      an_d = 6'b111111;
    else
      an_d = ~(6'b000001 << dig_q);
`ifdef SEG_SCAN6_BLINK_EN
    if (blink_cnt_q[BLINK_LOG2-1] && disp_if.blink[dig_q[2:1]])
      an_d = 6'b111111;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      dig_q     <= 3'd0;
      sh_hour_q <= 5'd0;
      sh_min_q  <= 6'd0;
      sh_sec_q  <= 6'd0;
      an_q      <= 6'b111111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      sh_hour_q <= sh_hour_d;
      sh_min_q  <= sh_min_d;
      sh_sec_q  <= sh_sec_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fs_q      <= fs_d;
    end
  end

  assign disp_if.an          = an_q;
  assign disp_if.seg         = seg_q;
  assign disp_if.dp          = dp_q;
  assign disp_if.frame_start = fs_q;
endmodule
